// File: rtl/wb_store_queue.sv
// wb_store_queue: WB store FIFO draining to dcache with load-conflict check; SQ_COALESCE_EN merges same-word stores
module wb_store_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             v_ex_dcache_write,
    input  logic [31:0]      WB_MEM_ADDR,
    input  logic [31:0]      WB_MEM_DATA,
    input  logic [3:0]       WB_MEM_BE,
    output logic             sq_full,
    output logic             sq_empty,
    output logic [PTR_W:0]   sq_count,
    output logic             SQ_DC_REQ,
    output logic [31:0]      SQ_DC_ADDR,
    output logic [31:0]      SQ_DC_DATA,
    output logic [3:0]       SQ_DC_BE,
    input  logic             DC_SQ_ACK,
    input  logic             MEM_RD_V,
    input  logic [31:0]      MEM_RD_ADDR,
    output logic             sq_rd_conflict
);
    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] head_q, tail_q, young;
    logic [PTR_W:0]   count_q;
    logic             push, pop, merge, merge_hit, hit, unused_lo;

    assign sq_count   = count_q;
    assign sq_empty   = count_q == '0;
    assign sq_full    = count_q == (PTR_W+1)'(DEPTH);
    assign SQ_DC_REQ  = !sq_empty;
    assign SQ_DC_ADDR = SQ_DC_REQ ? {addr_q[head_q], 2'b00} : '0;
    assign SQ_DC_DATA = SQ_DC_REQ ? data_q[head_q] : '0;
    assign SQ_DC_BE   = SQ_DC_REQ ? be_q[head_q] : '0;
    assign unused_lo  = ^{WB_MEM_ADDR[1:0], MEM_RD_ADDR[1:0]};

    // count>=2 keeps the youngest entry away from the head being presented
    assign young     = tail_q - PTR_W'(1);
    assign merge_hit = v_ex_dcache_write && count_q >= (PTR_W+1)'(2) && addr_q[young] == WB_MEM_ADDR[31:2];
`ifdef SQ_COALESCE_EN
    assign merge = merge_hit;
`else
    assign merge = 1'b0;
`endif
    assign push = v_ex_dcache_write && !sq_full && !merge;
    assign pop  = SQ_DC_REQ && DC_SQ_ACK;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // payload needs no reset: outputs and conflict are gated by count/valid bits
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail_q] <= WB_MEM_ADDR[31:2];
            data_q[tail_q] <= WB_MEM_DATA;
            be_q[tail_q]   <= WB_MEM_BE;
        end
        if (merge) begin
            for (int i = 0; i < 4; i++)
                if (WB_MEM_BE[i]) data_q[young][8*i +: 8] <= WB_MEM_DATA[8*i +: 8];
            be_q[young] <= be_q[young] | WB_MEM_BE;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            hit = hit | (vld_q[i] && addr_q[i] == MEM_RD_ADDR[31:2]);
    end

    assign sq_rd_conflict = MEM_RD_V && hit;
endmodule

// File: tb/tb_wb_store_queue.sv
// tb_wb_store_queue: scoreboard bench for wb_store_queue; drained stores checked by a monitor
module tb_wb_store_queue;
    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        v_ex_dcache_write = 1'b0;
    logic [31:0] WB_MEM_ADDR = '0;
    logic [31:0] WB_MEM_DATA = '0;
    logic [3:0]  WB_MEM_BE = '0;
    logic        sq_full, sq_empty, SQ_DC_REQ, sq_rd_conflict;
    logic [2:0]  sq_count;
    logic [31:0] SQ_DC_ADDR, SQ_DC_DATA;
    logic [3:0]  SQ_DC_BE;
    logic        DC_SQ_ACK = 1'b0;
    logic        MEM_RD_V = 1'b0;
    logic [31:0] MEM_RD_ADDR = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } st_t;
    st_t sb[$];
    int checks = 0;
    int errors = 0;

    wb_store_queue dut (
        .CLK(CLK), .CLR(CLR),
        .v_ex_dcache_write(v_ex_dcache_write),
        .WB_MEM_ADDR(WB_MEM_ADDR), .WB_MEM_DATA(WB_MEM_DATA), .WB_MEM_BE(WB_MEM_BE),
        .sq_full(sq_full), .sq_empty(sq_empty), .sq_count(sq_count),
        .SQ_DC_REQ(SQ_DC_REQ), .SQ_DC_ADDR(SQ_DC_ADDR), .SQ_DC_DATA(SQ_DC_DATA), .SQ_DC_BE(SQ_DC_BE),
        .DC_SQ_ACK(DC_SQ_ACK),
        .MEM_RD_V(MEM_RD_V), .MEM_RD_ADDR(MEM_RD_ADDR),
        .sq_rd_conflict(sq_rd_conflict)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        v_ex_dcache_write = 1'b1;
        WB_MEM_ADDR = a;
        WB_MEM_DATA = d;
        WB_MEM_BE = b;
        step();
    endtask

    task automatic expect_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        sb.push_back('{a, d, b});
    endtask

    task automatic drain();
        DC_SQ_ACK = 1'b1;
        for (int i = 0; i < 20 && !sq_empty; i++) step();
        DC_SQ_ACK = 1'b0;
        chk("drain_empty", 32'(sq_empty), 32'd1);
        chk("drain_sb_left", 32'(sb.size()), 32'd0);
    endtask

    // monitor: every accepted head is compared against the oldest expected store
    always @(negedge CLK) begin
        if (CLR && SQ_DC_REQ && DC_SQ_ACK) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_unexpected got %h expected none", SQ_DC_ADDR);
            end else begin
                st_t e;
                e = sb.pop_front();
                chk("drain_addr", SQ_DC_ADDR, e.a);
                chk("drain_data", SQ_DC_DATA, e.d);
                chk("drain_be", 32'(SQ_DC_BE), 32'(e.b));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        MEM_RD_V = 1'b1;
        repeat (2) step();
        chk("rst_empty", 32'(sq_empty), 32'd1);
        chk("rst_count", 32'(sq_count), 32'd0);
        chk("rst_req", 32'(SQ_DC_REQ), 32'd0);
        chk("rst_conflict", 32'(sq_rd_conflict), 32'd0);
        chk("rst_full", 32'(sq_full), 32'd0);
        CLR = 1'b1;
        MEM_RD_V = 1'b0;
        step();

        DC_SQ_ACK = 1'b1;
        step();
        chk("ack_idle_count", 32'(sq_count), 32'd0);
        DC_SQ_ACK = 1'b0;

        put(32'h0000_1006, 32'hAABB_CCDD, 4'b1100);
        v_ex_dcache_write = 1'b0;
        expect_st(32'h0000_1004, 32'hAABB_CCDD, 4'b1100);
        chk("single_req", 32'(SQ_DC_REQ), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("single_addr", SQ_DC_ADDR, 32'h0000_1004);
            chk("single_data", SQ_DC_DATA, 32'hAABB_CCDD);
            chk("single_be", 32'(SQ_DC_BE), 32'hC);
            step();
        end
        DC_SQ_ACK = 1'b1;
        step();
        DC_SQ_ACK = 1'b0;
        chk("single_empty", 32'(sq_empty), 32'd1);
        chk("single_req_off", 32'(SQ_DC_REQ), 32'd0);

        for (int i = 0; i < 4; i++) begin
            put(32'h4000 + 32'(i) * 32'h10, 32'hD000_0000 + 32'(i), 4'hF);
            expect_st(32'h4000 + 32'(i) * 32'h10, 32'hD000_0000 + 32'(i), 4'hF);
        end
        chk("fill_full", 32'(sq_full), 32'd1);
        chk("fill_count", 32'(sq_count), 32'd4);
        put(32'h4040, 32'hD000_0004, 4'hF);
        chk("fill_drop_a4", 32'(sq_count), 32'd4);
        DC_SQ_ACK = 1'b1;
        put(32'h4050, 32'hD000_0005, 4'hF);
        chk("full_push_pop_ignored", 32'(sq_count), 32'd3);
        for (int i = 5; i < 8; i++) begin
            put(32'h4000 + 32'(i) * 32'h10, 32'hD000_0000 + 32'(i), 4'hF);
            expect_st(32'h4000 + 32'(i) * 32'h10, 32'hD000_0000 + 32'(i), 4'hF);
            chk("wrap_count_steady", 32'(sq_count), 32'd3);
        end
        v_ex_dcache_write = 1'b0;
        repeat (3) step();
        chk("wrap_one_per_cycle", 32'(sq_empty), 32'd1);
        DC_SQ_ACK = 1'b0;
        chk("wrap_sb_left", 32'(sb.size()), 32'd0);

        v_ex_dcache_write = 1'b1;
        WB_MEM_ADDR = 32'h2000;
        WB_MEM_DATA = 32'h1111_1111;
        WB_MEM_BE = 4'hF;
        MEM_RD_V = 1'b1;
        MEM_RD_ADDR = 32'h2000;
        #1 chk("conf_same_cycle_push", 32'(sq_rd_conflict), 32'd0);
        step();
        expect_st(32'h2000, 32'h1111_1111, 4'hF);
        put(32'h3008, 32'h2222_2222, 4'hF);
        expect_st(32'h3008, 32'h2222_2222, 4'hF);
        v_ex_dcache_write = 1'b0;
        MEM_RD_ADDR = 32'h300B;
        #1 chk("conf_300b", 32'(sq_rd_conflict), 32'd1);
        MEM_RD_ADDR = 32'h300C;
        #1 chk("conf_300c", 32'(sq_rd_conflict), 32'd0);
        MEM_RD_ADDR = 32'h2003;
        #1 chk("conf_2003", 32'(sq_rd_conflict), 32'd1);
        MEM_RD_V = 1'b0;
        MEM_RD_ADDR = 32'h300B;
        #1 chk("conf_rdv_low", 32'(sq_rd_conflict), 32'd0);
        step();
        MEM_RD_V = 1'b1;
        MEM_RD_ADDR = 32'h2000;
        DC_SQ_ACK = 1'b1;
        #1 chk("conf_head_acked", 32'(sq_rd_conflict), 32'd1);
        drain();
        MEM_RD_V = 1'b0;

        put(32'h5000, 32'h5, 4'hF);
        put(32'h5010, 32'h6, 4'hF);
        put(32'h5020, 32'h7, 4'hF);
        v_ex_dcache_write = 1'b0;
        chk("mid_count", 32'(sq_count), 32'd3);
        chk("mid_req", 32'(SQ_DC_REQ), 32'd1);
        #2 CLR = 1'b0;
        #1;
        chk("async_req", 32'(SQ_DC_REQ), 32'd0);
        chk("async_count", 32'(sq_count), 32'd0);
        chk("async_full", 32'(sq_full), 32'd0);
        chk("async_empty", 32'(sq_empty), 32'd1);
        sb.delete();
        repeat (2) step();
        CLR = 1'b1;
        step();

        put(32'h100, 32'h11, 4'b0001);
        expect_st(32'h100, 32'h11, 4'b0001);
        put(32'h200, 32'h22, 4'b0001);
        put(32'h201, 32'h3300, 4'b0010);
        v_ex_dcache_write = 1'b0;
`ifdef SQ_COALESCE_EN
        expect_st(32'h200, 32'h0000_3322, 4'b0011);
        chk("coal_count", 32'(sq_count), 32'd2);
`else
        expect_st(32'h200, 32'h22, 4'b0001);
        expect_st(32'h200, 32'h3300, 4'b0010);
        chk("coal_count", 32'(sq_count), 32'd3);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_store_queue.md
Name: wb_store_queue

Overview:
- Receiving end of the writeback-stage memory write interface.
- Accepts validated dcache writes (`v_ex_dcache_write`) from WB in program order and buffers them in a FIFO.
- Drains entries to the dcache write port with a req/ack handshake.
- Gives the memory-read stage an address-conflict signal so loads cannot bypass older pending stores.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- CLR  input  1  asynchronous active-low reset.
- v_ex_dcache_write  input  1  push request from WB (already ANDed with WB_V).
- WB_MEM_ADDR  input  32  byte address of store.
- WB_MEM_DATA  input  32  store data, lane-aligned to WB_MEM_ADDR[31:2].
- WB_MEM_BE  input  4  byte enables; 4'b0000 is never pushed by WB.
- sq_full  output  1  queue full; WB stalls while 1.
- sq_empty  output  1  no valid entries.
- sq_count  output  PTR_W+1  number of valid entries.
- SQ_DC_REQ  output  1  head entry presented to dcache.
- SQ_DC_ADDR  output  32  head address, bits [1:0] forced to 0.
- SQ_DC_DATA  output  32  head data.
- SQ_DC_BE  output  4  head byte enables.
- DC_SQ_ACK  input  1  dcache accepted head this cycle.
- MEM_RD_V  input  1  memory stage performing a load.
- MEM_RD_ADDR  input  32  load byte address.
- sq_rd_conflict  output  1  load word address hits a pending store.

Behaviour:
- Reset (CLR=0, asynchronous):
  - head=0, tail=0, count=0; all entry valid bits 0.
  - Outputs: sq_empty=1, sq_full=0, sq_count=0, SQ_DC_REQ=0, SQ_DC_ADDR/DATA/BE=0, sq_rd_conflict=0.
  - Reset asserted mid-drain discards every entry, including a head awaiting ack.
- Push:
  - Accepted iff v_ex_dcache_write=1 and sq_full=0 at the rising edge.
  - Writes {ADDR[31:2], DATA, BE} at tail; tail increments and wraps DEPTH-1 -> 0.
  - A push while sq_full=1 is ignored, even if a pop occurs the same cycle; the queue does not track the stall.
- Pop:
  - Occurs iff SQ_DC_REQ=1 and DC_SQ_ACK=1 at the rising edge.
  - Head entry is invalidated; head increments with wrap.
  - DC_SQ_ACK while SQ_DC_REQ=0 has no effect.
- Same-cycle push and pop: both take effect and count is unchanged.
- Drain latency:
  - SQ_DC_REQ = !sq_empty, derived from registered state only.
  - A push into an empty queue raises SQ_DC_REQ on the next cycle; there is no same-cycle bypass.
  - SQ_DC_ADDR/DATA/BE are stable while REQ=1 and ack=0.
  - After an ack, the next entry (if any) is presented in the following cycle, so back-to-back acks give one store per cycle.
- Flags and count:
  - sq_full = (count==DEPTH) and sq_empty = (count==0), both from registered count.
  - sq_count equals count.
- Conflict:
  - sq_rd_conflict = MEM_RD_V AND (OR over valid entries of entry.addr[31:2]==MEM_RD_ADDR[31:2]).
  - Combinational over registered entries only; a same-cycle push is excluded.
  - Byte enables are ignored, so the check is conservative.
  - The head being acked this cycle still counts.
- Ordering: strict FIFO. Entries are never reordered and never dropped except on reset.

Optional Feature:
- Macro: SQ_COALESCE_EN.
- When defined:
  - A push whose ADDR[31:2] equals the youngest valid entry's address, with count>=2 (so that entry is not the head under REQ), merges into that entry instead of allocating.
  - Merge rule: for each byte with BE[i]=1, the entry's data byte i is replaced and BE[i] is ORed in.
  - count and tail do not change; a merge is accepted even when sq_full=1.
  - A merge never touches an entry presented on SQ_DC_*.
- When undefined: every accepted push allocates a new entry, exactly as in Behaviour.

Test Plan:
- Reset then idle:
  - Stimulus: CLR=0 for 2 cycles, release.
  - Required: sq_empty=1, sq_count=0, SQ_DC_REQ=0, sq_rd_conflict=0.
- Single store:
  - Stimulus: push ADDR=32'h0000_1006, DATA=32'hAABB_CCDD, BE=4'b1100; hold DC_SQ_ACK=0 for 3 cycles, then pulse 1.
  - Required: REQ rises the cycle after the push; outputs hold ADDR=32'h0000_1004, DATA=32'hAABB_CCDD, BE=4'b1100 throughout; queue is empty the cycle after the ack.
- Fill and wrap:
  - Stimulus: with DEPTH=4 and ack=0, push 5 distinct stores A0..A4; then assert ack continuously while pushing A5..A7.
  - Required: sq_full=1 after 4 pushes and A4 is dropped (WB must retry). Drain order is A0,A1,A2,A3,A5,A6,A7 at one per cycle, with pointers wrapping and count steady during simultaneous push+pop.
- Conflict:
  - Stimulus: queue holds ADDR 32'h2000 and 32'h3008; present MEM_RD_ADDR=32'h300B, then 32'h300C.
  - Required: sq_rd_conflict=1 for 32'h300B, 0 for 32'h300C; 0 whenever MEM_RD_V=0.
- Reset mid-drain:
  - Stimulus: 3 entries queued, REQ=1, ack=0; assert CLR asynchronously between clock edges.
  - Required: REQ, count, and full all return to 0 immediately, without waiting for a clock edge.
- Coalesce (SQ_COALESCE_EN):
  - Stimulus: ack=0; push 32'h100/BE 0001/DATA 11; push 32'h200/BE 0001/DATA 22; push 32'h201/BE 0010/DATA 3300.
  - Required: count=2 and the second entry reads DATA 32'h0000_3322, BE 0011. With the macro undefined, count=3.
